// File: rtl/clock_tick_divider_if.sv
// Configuration bus for clock_tick_divider: single-cycle write strobe with a registered ack/err reply.
interface clock_tick_divider_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = 24
);
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (output cfg_wr, cfg_ch, cfg_div, cfg_high, input  cfg_ack, cfg_err);
  modport slave  (input  cfg_wr, cfg_ch, cfg_div, cfg_high, output cfg_ack, cfg_err);
endinterface

// File: rtl/clock_tick_divider.sv
// Multi-channel programmable tick/level generator with shadowed, wrap-aligned reconfiguration.
// Optional realign on `sync` is enabled by defining CLKDIV_SYNC_EN.
module clock_tick_divider #(
  parameter int CHANNELS     = 2,
  parameter int CH_W         = 1,
  parameter int CNT_W        = 24,
  parameter int DEFAULT_DIV  = 500000,
  parameter int DEFAULT_HIGH = 250000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                sync,
  clock_tick_divider_if.slave bus,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] level
);
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t count    [CHANNELS];
  cnt_t div_act  [CHANNELS];
  cnt_t high_act [CHANNELS];
  cnt_t div_sh   [CHANNELS];
  cnt_t high_sh  [CHANNELS];
  logic [CHANNELS-1:0] pending;

  cnt_t cnt_nxt  [CHANNELS];
  cnt_t div_nxt  [CHANNELS];
  cnt_t high_nxt [CHANNELS];
  logic [CHANNELS-1:0] apply, wr_hit, tick_nxt, level_nxt;
  logic in_range;
  logic sync_go;

`ifdef CLKDIV_SYNC_EN
  assign sync_go = sync;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign sync_go     = 1'b0;
`endif

  assign in_range = int'(bus.cfg_ch) < CHANNELS;

  // NOTE: every variable is given a default before any condition, so no latch can be inferred.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_t d_m1;
      logic wrap;
      d_m1 = (div_act[c] < cnt_t'(2)) ? cnt_t'(1) : div_act[c] - cnt_t'(1);
      wrap = run && (count[c] == d_m1);

      apply[c]    = pending[c] && (sync_go || wrap);
      div_nxt[c]  = apply[c] ? div_sh[c]  : div_act[c];
      high_nxt[c] = apply[c] ? high_sh[c] : high_act[c];

      cnt_nxt[c] = count[c];
      if (sync_go || wrap) cnt_nxt[c] = '0;
      else if (run)        cnt_nxt[c] = count[c] + cnt_t'(1);

      // Sync beats step and wrap; step only acts while halted.
      tick_nxt[c]  = !sync_go && ((!run && step) || wrap);
      level_nxt[c] = cnt_nxt[c] < high_nxt[c];
      wr_hit[c]    = bus.cfg_wr && in_range && (bus.cfg_ch == CH_W'(c));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shadows are reset too, so an unwritten shadow never holds X even though pending gates it.
      for (int c = 0; c < CHANNELS; c++) begin
        count[c]    <= '0;
        div_act[c]  <= cnt_t'(DEFAULT_DIV);
        high_act[c] <= cnt_t'(DEFAULT_HIGH);
        div_sh[c]   <= cnt_t'(DEFAULT_DIV);
        high_sh[c]  <= cnt_t'(DEFAULT_HIGH);
      end
      pending     <= '0;
      tick        <= '0;
      level       <= '0;
      bus.cfg_ack <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        count[c]    <= cnt_nxt[c];
        div_act[c]  <= div_nxt[c];
        high_act[c] <= high_nxt[c];
        if (apply[c]) pending[c] <= 1'b0;
        // A write in the same cycle as an apply lands after it and stays pending.
        if (wr_hit[c]) begin
          div_sh[c]  <= bus.cfg_div;
          high_sh[c] <= bus.cfg_high;
          pending[c] <= 1'b1;
        end
      end
      tick        <= tick_nxt;
      level       <= level_nxt;
      bus.cfg_ack <= bus.cfg_wr;
      bus.cfg_err <= bus.cfg_wr && !in_range;
    end
  end
endmodule

// File: tb/tb_clock_tick_divider.sv
// Directed bench for clock_tick_divider (2 channels, 8-bit counters, default period 4, high 2).
module tb_clock_tick_divider;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 2;
  localparam int CNT_W    = 8;
`ifdef CLKDIV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, run, step, sync;
  logic [CHANNELS-1:0] tick, level;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  clock_tick_divider_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  clock_tick_divider #(
    .CHANNELS(CHANNELS), .CH_W(CH_W), .CNT_W(CNT_W),
    .DEFAULT_DIV(4), .DEFAULT_HIGH(2)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .sync(sync),
    .bus(bus.slave), .tick(tick), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input int ch, input int div, input int high);
    bus.cfg_wr   = 1'b1;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_div  = CNT_W'(div);
    bus.cfg_high = CNT_W'(high);
  endtask

  task automatic cfg_idle();
    bus.cfg_wr = 1'b0;
  endtask

  function automatic logic [1:0] pack2(input bit b1, input bit b0);
    return {b1, b0};
  endfunction

  initial begin
    int c0, c1;
    reset = 1'b1; run = 1'b0; step = 1'b0; sync = 1'b0;
    bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_high = '0;
    cfg_idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; run = 1'b1; cyc = 0;

    // Reset state and default period-4 / high-2 behaviour.
    check("rst_tick",  32'(tick),        32'd0);
    check("rst_level", 32'(level),       32'd0);
    check("rst_ack",   32'(bus.cfg_ack), 32'd0);
    check("rst_err",   32'(bus.cfg_err), 32'd0);
    repeat (12) begin
      advance();
      check("dflt_tick",  32'(tick),  (cyc % 4 == 0) ? 32'd3 : 32'd0);
      check("dflt_level", 32'(level), (cyc % 4 < 2)  ? 32'd3 : 32'd0);
    end

    // Reprogram ch1 mid-period, then an out-of-range write that must change nothing.
    while (cyc < 38) begin
      if (cyc == 13)      cfg_write(1, 6, 3);
      else if (cyc == 28) cfg_write(3, 9, 9);
      else                cfg_idle();
      advance();
      check("cfg_ack", 32'(bus.cfg_ack), 32'(cyc == 14 || cyc == 29));
      check("cfg_err", 32'(bus.cfg_err), 32'(cyc == 29));
      if (cyc < 16) begin
        check("reprog_tick",  32'(tick),  (cyc % 4 == 0) ? 32'd3 : 32'd0);
        check("reprog_level", 32'(level), (cyc % 4 < 2)  ? 32'd3 : 32'd0);
      end else begin
        check("reprog_tick",  32'(tick),  32'(pack2((cyc - 16) % 6 == 0, cyc % 4 == 0)));
        check("reprog_level", 32'(level), 32'(pack2((cyc - 16) % 6 < 3,  cyc % 4 < 2)));
      end
    end
    cfg_idle();

    // Halt with ch0 at count 2 (ch1 at 4), single step, then resume.
    run = 1'b0;
    advance();
    check("halt_tick",  32'(tick),  32'd0);
    check("halt_level", 32'(level), 32'd0);
    step = 1'b1;
    advance();
    check("step_tick",  32'(tick),  32'd3);
    check("step_level", 32'(level), 32'd0);
    step = 1'b0;
    advance();
    check("post_step_tick", 32'(tick), 32'd0);
    run = 1'b1;
    advance();
    check("resume1_tick",  32'(tick),  32'd0);
    check("resume1_level", 32'(level), 32'd0);
    advance();
    check("resume2_tick",  32'(tick),  32'd3);
    check("resume2_level", 32'(level), 32'd3);

    // Degenerate divisors: div=0 acts as 2 with level stuck high; high=0 keeps level low.
    while (cyc < 55) begin
      if (cyc == 43)      cfg_write(0, 0, 5);
      else if (cyc == 44) cfg_write(1, 3, 0);
      else                cfg_idle();
      advance();
      check("edge_ack", 32'(bus.cfg_ack), 32'(cyc == 44 || cyc == 45));
      check("edge_err", 32'(bus.cfg_err), 32'd0);
      check("edge_tick", 32'(tick),
            32'(pack2(cyc >= 49 && (cyc - 49) % 3 == 0, cyc >= 47 && (cyc - 47) % 2 == 0)));
      check("edge_level", 32'(level),
            32'(pack2(cyc == 44 || cyc == 45, cyc == 44 || cyc >= 47)));
    end

    // Pending write and writes during reset must be lost.
    cfg_write(0, 9, 1);
    advance();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
    cyc = 0;
    check("rst2_ack", 32'(bus.cfg_ack), 32'd0);

    // Put ch1 two counts ahead of ch0, then realign with sync at cycle 13.
    while (cyc < 18) begin
      if (cyc == 0)      cfg_write(1, 6, 2);
      else if (cyc == 5) cfg_write(1, 4, 2);
      else               cfg_idle();
      sync = (cyc == 13);
      advance();
      c0 = cyc % 4;
      if (cyc < 4)       c1 = cyc % 4;
      else if (cyc < 10) c1 = (cyc - 4) % 6;
      else               c1 = (cyc - 10) % 4;
      if (SYNC_ON && cyc >= 14) begin
        c0 = (cyc - 14) % 4;
        c1 = (cyc - 14) % 4;
      end
      check("sync_tick", 32'(tick),
            (SYNC_ON && cyc == 14) ? 32'd0 : 32'(pack2(c1 == 0, c0 == 0)));
      check("sync_level", 32'(level), 32'(pack2(c1 < 2, c0 < 2)));
    end
    sync = 1'b0;
    cfg_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
